// File: rtl/gost_round_sched.sv
// Iterative GOST 28147-89 round scheduler: drives one external round unit for NROUNDS cycles.
// Optional `GOST_SCHED_ZEROIZE_EN clears key and L/R state on output transfer.
module gost_round_sched #(
  parameter int NROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [64:1]  in_data,
  input  logic [256:1] in_key,
  input  logic         in_decrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [64:1]  out_data,
  output logic         busy,
  output logic [32:1]  rnd_n1,
  output logic [32:1]  rnd_k,
  input  logic [32:1]  rnd_f,
  output logic [5:0]   rnd_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] LAST    = 6'(NROUNDS - 1);
  localparam logic [5:0] ENC_REV = 6'(NROUNDS - 8);

  state_t           state;
  logic [31:0]      l_q, r_q;
  logic [7:0][31:0] key_q;
  logic             dec_q;
  logic [5:0]       r_idx;
  logic [2:0]       ksel;
  logic             accept;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign out_data  = {r_q, l_q};
  assign rnd_n1    = l_q;
  assign rnd_k     = key_q[ksel];
  assign rnd_idx   = r_idx;

  // Reversed segment: encrypt runs the last 8 rounds backwards, decrypt all but the first 8.
  always_comb begin
    ksel = r_idx[2:0];
    if (state != RUN)
      ksel = 3'd0;
    else if (dec_q ? (r_idx >= 6'd8) : (r_idx >= ENC_REV))
      ksel = ~r_idx[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      l_q   <= '0;
      r_q   <= '0;
      key_q <= '0;
      dec_q <= 1'b0;
      r_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            l_q   <= in_data[64:33];
            r_q   <= in_data[32:1];
            for (int j = 0; j < 8; j++)
              key_q[j] <= in_key[256-32*j -: 32];
            dec_q <= in_decrypt;
            r_idx <= '0;
            state <= RUN;
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
`ifdef GOST_SCHED_ZEROIZE_EN
            l_q   <= '0;
            r_q   <= '0;
            key_q <= '0;
            dec_q <= 1'b0;
`endif
          end
        end
        RUN: begin
          r_q <= l_q;
          l_q <= r_q ^ rnd_f;
          if (r_idx == LAST) begin
            r_idx <= '0;
            state <= DONE;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gost_round_sched.sv
// Directed bench for gost_round_sched: handshake, latency, key order, round trip, backpressure, reset.
module tb_gost_round_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_decrypt;
  logic [64:1]  in_data;
  logic [256:1] in_key;
  logic         out_valid, out_ready;
  logic [64:1]  out_data;
  logic         busy;
  logic [32:1]  rnd_n1, rnd_k, rnd_f;
  logic [5:0]   rnd_idx;

  int n_vec = 0;
  int n_err = 0;
  logic use_real;

  localparam logic [256:1] KEY_SEQ = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                      32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
  localparam logic [256:1] KEY_RT  = {32'hFFEEDDCC, 32'hBBAA9988, 32'h77665544, 32'h33221100,
                                      32'hF0F1F2F3, 32'hF4F5F6F7, 32'hF8F9FAFB, 32'hFCFDFEFF};

  always #5 clk = ~clk;

  gost_round_sched #(.NROUNDS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .rnd_n1(rnd_n1), .rnd_k(rnd_k), .rnd_f(rnd_f), .rnd_idx(rnd_idx)
  );

  // Stand-in round unit: add, one 4-bit S-box on every nibble, rotate left 11.
  function automatic logic [31:0] round_fn(input logic [31:0] n1, input logic [31:0] k);
    logic [63:0] sb;
    logic [31:0] s, t;
    sb = 64'h35F7C1B6E08D29A4;
    s  = n1 + k;
    for (int i = 0; i < 8; i++)
      t[4*i +: 4] = sb[4*s[4*i +: 4] +: 4];
    return {t[20:0], t[31:21]};
  endfunction

  always_comb rnd_f = use_real ? round_fn(rnd_n1, rnd_k) : 32'h0;

  task automatic start_block(input logic [64:1] d, input logic [256:1] k, input logic dec);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_key = k; in_decrypt = dec;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drain;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_vec += 7;
    if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (rnd_idx !== 6'd0)    begin n_err++; $display("FAIL reset_rnd_idx got %0d exp 0", rnd_idx); end
    if (out_data !== 64'h0)  begin n_err++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    if (rnd_n1 !== 32'h0)    begin n_err++; $display("FAIL reset_rnd_n1 got %h exp 0", rnd_n1); end
    if (rnd_k !== 32'h0)     begin n_err++; $display("FAIL reset_rnd_k got %h exp 0", rnd_k); end
  endtask

  task automatic test_passthrough;
    int n;
    use_real = 1'b0;
    start_block(64'h0123456789ABCDEF, KEY_SEQ, 1'b0);
    wait_done(n);
    n_vec += 4;
    if (n !== 32) begin n_err++; $display("FAIL pass_latency got %0d exp 32", n); end
    if (out_data !== 64'h89ABCDEF01234567)
      begin n_err++; $display("FAIL pass_out_data got %h exp 89abcdef01234567", out_data); end
    drain;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_err++; $display("FAIL pass_back_idle got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
`ifdef GOST_SCHED_ZEROIZE_EN
    if (rnd_k !== 32'h0) begin n_err++; $display("FAIL idle_rnd_k got %h exp 0", rnd_k); end
`else
    if (rnd_k !== 32'h11111111) begin n_err++; $display("FAIL idle_rnd_k got %h exp 11111111", rnd_k); end
`endif
  endtask

  task automatic test_key_order(input logic dec);
    logic [31:0] exp_k;
    int          w;
    use_real = 1'b0;
    start_block(64'h0, KEY_SEQ, dec);
    for (int r = 0; r < 32; r++) begin
      if (dec) w = (r < 8)  ? r : 7 - (r % 8);
      else     w = (r < 24) ? (r % 8) : 7 - (r % 8);
      exp_k = 32'h11111111 * (w + 1);
      n_vec += 2;
      if (rnd_idx !== 6'(r))
        begin n_err++; $display("FAIL key_idx dec=%b r=%0d got %0d", dec, r, rnd_idx); end
      if (rnd_k !== exp_k)
        begin n_err++; $display("FAIL key_order dec=%b r=%0d got %h exp %h", dec, r, rnd_k, exp_k); end
      @(posedge clk); #1;
    end
    n_vec++;
    if (out_valid !== 1'b1 || rnd_k !== 32'h11111111 || rnd_idx !== 6'd0)
      begin n_err++; $display("FAIL key_done dec=%b got v=%b k=%h idx=%0d", dec, out_valid, rnd_k, rnd_idx); end
    drain;
  endtask

  task automatic test_round_trip;
    int n;
    logic [64:1] ct;
    use_real = 1'b1;
    start_block(64'hFEDCBA9876543210, KEY_RT, 1'b0);
    wait_done(n);
    ct = out_data;
    n_vec += 2;
    if (n !== 32) begin n_err++; $display("FAIL rt_enc_latency got %0d exp 32", n); end
    if (ct === 64'hFEDCBA9876543210)
      begin n_err++; $display("FAIL rt_cipher_changed got %h exp not plaintext", ct); end
    drain;
    start_block(ct, KEY_RT, 1'b1);
    wait_done(n);
    n_vec++;
    if (out_data !== 64'hFEDCBA9876543210)
      begin n_err++; $display("FAIL rt_decrypt got %h exp fedcba9876543210", out_data); end
    drain;
    use_real = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n;
    use_real = 1'b0;
    start_block(64'hAAAA5555CCCC3333, KEY_SEQ, 1'b0);
    wait_done(n);
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'h0000111122223333; in_key = KEY_SEQ; in_decrypt = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_vec += 2;
      if (out_data !== 64'hCCCC3333AAAA5555)
        begin n_err++; $display("FAIL stall_data c=%0d got %h exp cccc3333aaaa5555", c, out_data); end
      if (in_ready !== 1'b0)
        begin n_err++; $display("FAIL stall_in_ready c=%0d got %b exp 0", c, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec += 3;
    if (busy !== 1'b1)      begin n_err++; $display("FAIL b2b_busy got %b exp 1", busy); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_out_valid got %b exp 0", out_valid); end
    if (rnd_idx !== 6'd0)   begin n_err++; $display("FAIL b2b_rnd_idx got %0d exp 0", rnd_idx); end
    wait_done(n);
    n_vec += 2;
    if (n !== 32) begin n_err++; $display("FAIL b2b_latency got %0d exp 32", n); end
    if (out_data !== 64'h2222333300001111)
      begin n_err++; $display("FAIL b2b_out_data got %h exp 2222333300001111", out_data); end
    drain;
  endtask

  task automatic test_reset_mid_run;
    int n;
    logic seen;
    start_block(64'h1234567890ABCDEF, KEY_SEQ, 1'b0);
    n = 0;
    while (rnd_idx !== 6'd17 && n < 50) begin @(posedge clk); #1; n++; end
    n_vec++;
    if (rnd_idx !== 6'd17) begin n_err++; $display("FAIL rst_reach17 got %0d exp 17", rnd_idx); end
    #2 rst_n = 1'b0;
    #1;
    n_vec += 4;
    if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    if (in_ready !== 1'b1)  begin n_err++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    if (rnd_idx !== 6'd0 || rnd_n1 !== 32'h0 || rnd_k !== 32'h0)
      begin n_err++; $display("FAIL rst_regs got idx=%0d n1=%h k=%h exp 0", rnd_idx, rnd_n1, rnd_k); end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL rst_no_output got %b exp 0", seen); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; in_decrypt = 1'b0;
    out_ready = 1'b0; use_real = 1'b0;
    #22 rst_n = 1'b1;
    #1;
    test_reset;
    test_passthrough;
    test_key_order(1'b0);
    test_key_order(1'b1);
    test_round_trip;
    test_back_to_back;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
